icache: RTL

//  Instruction-side memory responder for the pipelined MIPS datapath: answers the datapath's

---
 rtl/icache_if.sv | 35 +++
 rtl/icache.sv | 122 ++++++++++++
 2 files changed

// File: rtl/icache_if.sv
// rtl/icache_if.sv - datapath fetch port and memory refill port of the instruction cache
// ICACHE_STATS_EN adds the hit_count/miss_count observation outputs.
interface icache_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        flush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr, hit_count, miss_count
  );
`else
  modport slave (
    input  imemREN, imemaddr, flush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );
  modport master (
    output imemREN, imemaddr, flush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );
`endif
endinterface

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped, one-word-block instruction cache with single-word refill
// ICACHE_STATS_EN enables saturating hit/miss counters.
module icache #(
  parameter int SETS = 16
) (
  input  logic    CLK,
  input  logic    nRST,
  icache_if.slave bus
);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [31:0]       r_data [SETS];
  logic [31:0]       r_miss_addr;

  logic [IDX_W-1:0]  w_idx;
  logic [IDX_W-1:0]  w_fill_idx;
  logic [TAG_W-1:0]  w_tag;
  logic [TAG_W-1:0]  w_fill_tag;
  logic              w_match;
  logic              w_ihit;
  logic              w_miss;
  logic              w_fill;
  logic              w_iren;
  logic              w_unused_lsb;

  assign w_idx        = bus.imemaddr[IDX_W+1:2];
  assign w_tag        = bus.imemaddr[31:IDX_W+2];
  assign w_fill_idx   = r_miss_addr[IDX_W+1:2];
  assign w_fill_tag   = r_miss_addr[31:IDX_W+2];
  assign w_match      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused_lsb = ^bus.imemaddr[1:0];

  always_comb begin
    w_next_state = r_state;
    w_ihit       = 1'b0;
    w_miss       = 1'b0;
    w_fill       = 1'b0;
    w_iren       = 1'b0;
    case (r_state)
      IDLE: begin
        w_ihit = bus.imemREN && w_match && !bus.flush;
        w_miss = bus.imemREN && !w_ihit;
        if (w_miss) begin
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        // Refill is tied to the latched miss address; the live request is ignored here.
        w_iren = 1'b1;
        if (!bus.iwait) begin
          w_fill       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.ihit     = w_ihit;
  assign bus.imemload = w_ihit ? r_data[w_idx] : 32'h0;
  assign bus.iREN     = w_iren;
  assign bus.iaddr    = w_iren ? r_miss_addr : 32'h0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= IDLE;
      r_miss_addr <= 32'h0;
    end else begin
      r_state <= w_next_state;
      if (w_miss) begin
        r_miss_addr <= {bus.imemaddr[31:2], 2'b00};
      end
    end
  end

  // Flush has priority so a refill landing in the flush cycle stays invalid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid <= '0;
    end else if (bus.flush) begin
      r_valid <= '0;
    end else if (w_fill) begin
      r_valid[w_fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fill) begin
      r_tag[w_fill_idx]  <= w_fill_tag;
      r_data[w_fill_idx] <= bus.iload;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_hit_count  <= 32'h0;
      r_miss_count <= 32'h0;
    end else begin
      if (w_ihit && (r_hit_count != 32'hFFFF_FFFF)) begin
        r_hit_count <= r_hit_count + 32'd1;
      end
      if (w_miss && (r_miss_count != 32'hFFFF_FFFF)) begin
        r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign bus.hit_count  = r_hit_count;
  assign bus.miss_count = r_miss_count;
`endif
endmodule
